// File: rtl/alu_exec_pkg.sv
// alu_exec_pkg
// Shared definitions for the ALU execute stage: datapath widths, opcode
// constants, the stage state enum and the single-cycle ALU helper function.
// Optional feature macro: ALU_MUL_EN (opcode 7 becomes an iterative multiply;
// otherwise opcode 7 is MOV).
package alu_exec_pkg;

  localparam int WIDTH   = 8;
  localparam int ADDR_W  = 3;
  localparam int OP_W    = 3;
  localparam int SHAMT_W = $clog2(WIDTH);

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_AND = 3'd2;
  localparam logic [OP_W-1:0] OP_OR  = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR = 3'd4;
  localparam logic [OP_W-1:0] OP_SHL = 3'd5;
  localparam logic [OP_W-1:0] OP_SHR = 3'd6;
  localparam logic [OP_W-1:0] OP_MUL = 3'd7;

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } state_e;

  // Single-cycle ALU. Returns {flag_c, result}. Opcode 7 is treated as MOV
  // here; when the multiplier is built the stage diverts opcode 7 to it
  // before this result is ever used.
  function automatic logic [WIDTH:0] alu_single(
    input logic [OP_W-1:0]  op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [SHAMT_W-1:0] sh;
    logic [WIDTH:0]     r;
    logic [WIDTH:0]     t;
    sh = b[SHAMT_W-1:0];
    r  = '0;
    t  = '0;
    case (op)
      OP_ADD: r = {1'b0, a} + {1'b0, b};
      // Borrow appears in the extra top bit when a < b.
      OP_SUB: r = {1'b0, a} - {1'b0, b};
      OP_AND: r = {1'b0, a & b};
      OP_OR:  r = {1'b0, a | b};
      OP_XOR: r = {1'b0, a ^ b};
      // The extra top bit catches the last bit shifted out (0 for sh == 0).
      OP_SHL: r = {1'b0, a} << sh;
      // Shift with a guard bit below the LSB; the guard ends up holding the
      // last bit shifted out, then gets moved to the carry position.
      OP_SHR: begin
        t = {a, 1'b0} >> sh;
        r = {t[0], t[WIDTH:1]};
      end
      default: r = {1'b0, b};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_exec_if.sv
// alu_exec_if
// Request / write-back bundle between the upstream issue logic (master) and
// the execute stage (slave).
//   in_valid/in_ready  request handshake
//   op, rd, a, b       opcode, destination register, operands
//   wb_valid/addr/data write-back to the register file
//   flag_z, flag_c     result flags, held between write-backs
interface alu_exec_if;
  import alu_exec_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   op;
  logic [ADDR_W-1:0] rd;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [WIDTH-1:0]  wb_data;
  logic              flag_z;
  logic              flag_c;

  modport master (
    output in_valid, op, rd, a, b,
    input  in_ready, wb_valid, wb_addr, wb_data, flag_z, flag_c
  );

  modport slave (
    input  in_valid, op, rd, a, b,
    output in_ready, wb_valid, wb_addr, wb_data, flag_z, flag_c
  );

endinterface

// File: rtl/mul8_shift_add.sv
// mul8_shift_add
// Iterative WIDTH x WIDTH shift-add multiplier, one partial product per clock.
// Only built when ALU_MUL_EN is defined.
//   clk, reset  clock, synchronous active-high reset (aborts any operation)
//   start       load operands (iteration count cleared)
//   a, b        multiplicand, multiplier
//   done        high in the cycle of the final iteration
//   prod        full 2*WIDTH product, valid while done is high
`ifdef ALU_MUL_EN
module mul8_shift_add
  #(parameter int WIDTH = 8)
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);
  localparam int CNT_W = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               busy_reg;
  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] sum_next;

  // Partial product: the shifted multiplicand gated by the current LSB.
  generate
    for (genvar gi = 0; gi < 2*WIDTH; gi++) begin : g_addend
      assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
    end
  endgenerate

  assign sum_next = acc_reg + addend;

  // The last iteration's sum is presented combinationally so the stage can
  // register it on the same edge that completes the iteration.
  assign done = busy_reg && (cnt_reg == CNT_W'(WIDTH-1));
  assign prod = sum_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_reg  <= '0;
      acc_reg    <= '0;
      mplier_reg <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
    end else if (start) begin
      mcand_reg  <= {{WIDTH{1'b0}}, a};
      mplier_reg <= b;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b1;
    end else if (busy_reg) begin
      acc_reg    <= sum_next;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      cnt_reg    <= cnt_reg + 1'b1;
      if (done) begin
        busy_reg <= 1'b0;
      end
    end
  end

endmodule
`endif

// File: rtl/alu_exec_stage.sv
// alu_exec_stage
// Execute stage behind the 8x8 register file. Accepts an opcode, destination
// and two operands, and produces a one-cycle write-back pulse plus flags.
//   clk, reset  clock, synchronous active-high reset
//   bus         alu_exec_if.slave: request handshake, write-back, flags
// Optional feature macro: ALU_MUL_EN
//   defined   -> opcode 7 is an 8-iteration shift-add multiply (in_ready low
//                while it runs; write-back in the first cycle in_ready is back)
//   undefined -> opcode 7 is MOV (wb_data = b), single-cycle; never busy
module alu_exec_stage
  import alu_exec_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  alu_exec_if.slave bus
);

  state_e             state_reg;
  logic               wb_valid_reg;
  logic [ADDR_W-1:0]  wb_addr_reg;
  logic [WIDTH-1:0]   wb_data_reg;
  logic               flag_z_reg;
  logic               flag_c_reg;
  logic [ADDR_W-1:0]  mul_rd_reg;

  logic               accept;
  logic               take_mul;
  logic [WIDTH:0]     single_res;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  assign accept     = bus.in_valid && (state_reg == IDLE);
  assign single_res = alu_single(bus.op, bus.a, bus.b);

`ifdef ALU_MUL_EN
  logic mul_start;

  assign take_mul  = (bus.op == OP_MUL);
  assign mul_start = accept && take_mul;

  mul8_shift_add #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .reset (reset),
    .start (mul_start),
    .a     (bus.a),
    .b     (bus.b),
    .done  (mul_done),
    .prod  (mul_prod)
  );
`else
  assign take_mul = 1'b0;
  assign mul_done = 1'b0;
  assign mul_prod = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      wb_valid_reg <= 1'b0;
      wb_addr_reg  <= '0;
      wb_data_reg  <= '0;
      flag_z_reg   <= 1'b0;
      flag_c_reg   <= 1'b0;
      mul_rd_reg   <= '0;
    end else begin
      wb_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (take_mul) begin
              // Destination is parked until the product is ready.
              mul_rd_reg <= bus.rd;
              state_reg  <= MUL_BUSY;
            end else begin
              wb_valid_reg <= 1'b1;
              wb_addr_reg  <= bus.rd;
              wb_data_reg  <= single_res[WIDTH-1:0];
              flag_z_reg   <= (single_res[WIDTH-1:0] == '0);
              flag_c_reg   <= single_res[WIDTH];
            end
          end
        end
        MUL_BUSY: begin
          if (mul_done) begin
            wb_valid_reg <= 1'b1;
            wb_addr_reg  <= mul_rd_reg;
            wb_data_reg  <= mul_prod[WIDTH-1:0];
            flag_z_reg   <= (mul_prod[WIDTH-1:0] == '0);
            // Carry signals that the product overflowed the low byte.
            flag_c_reg   <= |mul_prod[2*WIDTH-1:WIDTH];
            state_reg    <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.in_ready = (state_reg == IDLE);
  assign bus.wb_valid = wb_valid_reg;
  assign bus.wb_addr  = wb_addr_reg;
  assign bus.wb_data  = wb_data_reg;
  assign bus.flag_z   = flag_z_reg;
  assign bus.flag_c   = flag_c_reg;

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage
// Self-checking bench for alu_exec_stage: directed cases followed by random
// traffic, all compared against a cycle-level behavioural model.
module tb_alu_exec_stage;
  import alu_exec_pkg::*;

`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_exec_if bus();

  alu_exec_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  int busy_left = 0;
  int exp_valid = 0;
  int exp_addr  = 0;
  int exp_data  = 0;
  int exp_z     = 0;
  int exp_c     = 0;
  int pend_addr = 0;
  int pend_data = 0;
  int pend_c    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the opcode definitions.
  task automatic ref_calc(input int op, input int a, input int b,
                          output int data, output int c);
    int s;
    s = b % 8;
    data = 0;
    c = 0;
    case (op)
      0: begin data = (a + b) % 256; c = (a + b > 255) ? 1 : 0; end
      1: begin data = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
      2: data = a & b;
      3: data = a | b;
      4: data = a ^ b;
      5: begin data = (a * (1 << s)) % 256; c = (s == 0) ? 0 : (a / (1 << (8 - s))) % 2; end
      6: begin data = a / (1 << s); c = (s == 0) ? 0 : (a / (1 << (s - 1))) % 2; end
      default: begin
        if (MUL_EN) begin
          data = (a * b) % 256;
          c = (a * b > 255) ? 1 : 0;
        end else begin
          data = b;
          c = 0;
        end
      end
    endcase
  endtask

  // One clock: apply inputs, advance the model across the edge, then compare.
  task automatic step(input bit rst, input bit v, input int op, input int rd,
                      input int a, input int b);
    int d, c;
    reset        = rst;
    bus.in_valid = v;
    bus.op       = 3'(op);
    bus.rd       = 3'(rd);
    bus.a        = 8'(a);
    bus.b        = 8'(b);
    @(posedge clk);
    if (rst) begin
      busy_left = 0;
      exp_valid = 0;
      exp_addr  = 0;
      exp_data  = 0;
      exp_z     = 0;
      exp_c     = 0;
    end else begin
      exp_valid = 0;
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin
          exp_valid = 1;
          exp_addr  = pend_addr;
          exp_data  = pend_data;
          exp_c     = pend_c;
          exp_z     = (pend_data == 0) ? 1 : 0;
        end
      end else if (v) begin
        ref_calc(op, a, b, d, c);
        if (op == 7 && MUL_EN) begin
          busy_left = 8;
          pend_addr = rd;
          pend_data = d;
          pend_c    = c;
        end else begin
          exp_valid = 1;
          exp_addr  = rd;
          exp_data  = d;
          exp_c     = c;
          exp_z     = (d == 0) ? 1 : 0;
        end
      end
    end
    #1;
    check("in_ready", 32'(bus.in_ready), (busy_left == 0) ? 32'd1 : 32'd0);
    check("wb_valid", 32'(bus.wb_valid), 32'(exp_valid));
    check("wb_addr",  32'(bus.wb_addr),  32'(exp_addr));
    check("wb_data",  32'(bus.wb_data),  32'(exp_data));
    check("flag_z",   32'(bus.flag_z),   32'(exp_z));
    check("flag_c",   32'(bus.flag_c),   32'(exp_c));
    if (bus.wb_valid === 1'b1)
      $display("wb: addr=%0d data=0x%02h z=%0d c=%0d t=%0t",
               bus.wb_addr, bus.wb_data, bus.flag_z, bus.flag_c, $time);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.op = '0;
    bus.rd = '0;
    bus.a  = '0;
    bus.b  = '0;

    // Reset state
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // ADD with carry out
    step(0, 1, 0, 3, 'hF0, 'h20);
    step(0, 0, 0, 0, 0, 0);
    // SUB equal (zero) and SUB with borrow
    step(0, 1, 1, 1, 'h05, 'h05);
    step(0, 1, 1, 2, 'h03, 'h05);
    // Back-to-back logic ops
    step(0, 1, 2, 4, 'hCC, 'hAA);
    step(0, 1, 3, 5, 'hCC, 'hAA);
    step(0, 1, 4, 6, 'hCC, 'hAA);
    // Shifts: zero amount, and amounts that shift out a one
    step(0, 1, 5, 1, 'h81, 'h00);
    step(0, 1, 5, 1, 'h81, 'h01);
    step(0, 1, 6, 2, 'h81, 'h01);
    step(0, 1, 6, 2, 'h81, 'h07);
    step(0, 0, 0, 0, 0, 0);

    // Opcode 7 (MUL when built, MOV otherwise), then an ADD held on the bus
    step(0, 1, 7, 5, 'h0C, 'h15);
    for (int i = 0; i < 9; i++) step(0, 1, 0, 7, 'h11, 'h22);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 7, 6, 'h10, 'h10);
    for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 0, 0);

    // Reset partway through opcode 7
    step(0, 1, 7, 4, 'h33, 'h77);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 0);

    // MOV-style operand pass-through case
    step(0, 1, 7, 2, 'h00, 'h5A);
    for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 0, 0);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      int a, b, sel;
      sel = $urandom_range(0, 9);
      a = (sel == 0) ? 0 : (sel == 1) ? 255 : $urandom_range(0, 255);
      b = (sel == 2) ? 0 : (sel == 3) ? 255 : $urandom_range(0, 255);
      step(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
           $urandom_range(0, 7), $urandom_range(0, 7), a, b);
    end
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
